sc_race_timebase: RTL and testbench

SC_RACE_TIMEBASE -- requirements
Module: sc_race_timebase

---
 rtl/sc_race_timebase_pkg.sv | 14 +
 rtl/sc_race_prescaler.sv | 50 +++++
 rtl/sc_race_timebase.sv | 107 ++++++++++
 tb/tb_sc_race_timebase.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_race_timebase_pkg.sv
// rtl/sc_race_timebase_pkg.sv - shared state encodings and default sizing for the race timebase
package sc_race_timebase_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_TIMEOUT = 2'b11
  } rt_state_e;

  localparam int unsigned RT_DEFAULT_DIVISOR   = 50000000;
  localparam int unsigned RT_DEFAULT_DATAWIDTH = 8;

endpackage

// File: rtl/sc_race_prescaler.sv
// rtl/sc_race_prescaler.sv - divide-by-DIVISOR counter with a registered terminal-count pulse
module sc_race_prescaler
  import sc_race_timebase_pkg::*;
#(
  parameter int unsigned DIVISOR = RT_DEFAULT_DIVISOR
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic last,
  output logic tc
);

  localparam int unsigned W = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [W-1:0] LAST_VAL = W'(DIVISOR - 1);

  logic [W-1:0] count_q, count_d;
  logic         tc_q, tc_d;

  assign last = (count_q == LAST_VAL);
  assign tc   = tc_q;

  // Clear outranks enable so a same-cycle clear never leaks a pulse.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (last) begin
        count_d = '0;
        tc_d    = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

endmodule

// File: rtl/sc_race_timebase.sv
// rtl/sc_race_timebase.sv - race countdown FSM: start/pause/clear, seconds register and tick output
module sc_race_timebase
  import sc_race_timebase_pkg::*;
#(
  parameter int unsigned RaceTimebase_DIVISOR   = RT_DEFAULT_DIVISOR,
  parameter int unsigned RaceTimebase_DATAWIDTH = RT_DEFAULT_DATAWIDTH
) (
  input  logic                              SC_RaceTimebase_CLOCK_50,
  input  logic                              SC_RaceTimebase_RESET_InLow,
  input  logic                              SC_RaceTimebase_START_InHigh,
  input  logic                              SC_RaceTimebase_PAUSE_InHigh,
  input  logic                              SC_RaceTimebase_CLEAR_InHigh,
  input  logic [RaceTimebase_DATAWIDTH-1:0] SC_RaceTimebase_LOAD_InBUS,
  output logic                              SC_RaceTimebase_TICK_OutHigh,
  output logic [RaceTimebase_DATAWIDTH-1:0] SC_RaceTimebase_SECONDS_OutBUS,
  output logic [1:0]                        SC_RaceTimebase_STATE_OutBUS,
  output logic                              SC_RaceTimebase_TIMEOUT_OutHigh
);

  localparam int unsigned DW = RaceTimebase_DATAWIDTH;

  rt_state_e         state_q, state_d;
  logic [DW-1:0]     seconds_q, seconds_d;
  logic              pre_en, pre_clr, pre_last, pre_tc;

  logic clear, pause, start;
  assign clear = SC_RaceTimebase_CLEAR_InHigh;
  assign pause = SC_RaceTimebase_PAUSE_InHigh;
  assign start = SC_RaceTimebase_START_InHigh;

  sc_race_prescaler #(
    .DIVISOR(RaceTimebase_DIVISOR)
  ) u_prescaler (
    .clk  (SC_RaceTimebase_CLOCK_50),
    .rst_n(SC_RaceTimebase_RESET_InLow),
    .en   (pre_en),
    .clr  (pre_clr),
    .last (pre_last),
    .tc   (pre_tc)
  );

  // Priority CLEAR > PAUSE > START; the prescaler only advances on an uncontested RUNNING cycle.
  always_comb begin
    state_d   = state_q;
    seconds_d = seconds_q;
    pre_en    = 1'b0;
    pre_clr   = 1'b0;
    if (clear) begin
      state_d   = ST_IDLE;
      seconds_d = '0;
      pre_clr   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pre_clr = 1'b1;
          if (!pause && start) begin
            seconds_d = SC_RaceTimebase_LOAD_InBUS;
            state_d   = (SC_RaceTimebase_LOAD_InBUS != '0) ? ST_RUNNING : ST_TIMEOUT;
          end
        end
        ST_RUNNING: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else begin
            pre_en = 1'b1;
            if (pre_last) begin
              if (seconds_q <= DW'(1)) begin
                seconds_d = '0;
                state_d   = ST_TIMEOUT;
              end else begin
                seconds_d = seconds_q - 1'b1;
              end
            end
          end
        end
        ST_PAUSED: begin
          if (!pause && start) begin
            state_d = ST_RUNNING;
          end
        end
        ST_TIMEOUT: begin
          pre_clr = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          pre_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge SC_RaceTimebase_CLOCK_50 or negedge SC_RaceTimebase_RESET_InLow) begin
    if (!SC_RaceTimebase_RESET_InLow) begin
      state_q   <= ST_IDLE;
      seconds_q <= '0;
    end else begin
      state_q   <= state_d;
      seconds_q <= seconds_d;
    end
  end

  assign SC_RaceTimebase_TICK_OutHigh    = pre_tc;
  assign SC_RaceTimebase_SECONDS_OutBUS  = seconds_q;
  assign SC_RaceTimebase_STATE_OutBUS    = state_q;
  assign SC_RaceTimebase_TIMEOUT_OutHigh = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_sc_race_timebase.sv
// tb/tb_sc_race_timebase.sv - directed bench for sc_race_timebase with DIVISOR=4
module tb_sc_race_timebase;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] load = 8'd0;
  logic       tick;
  logic [7:0] seconds;
  logic [1:0] state;
  logic       timeout;

  int total = 0;
  int bad = 0;

  // Observation word: {state, timeout, tick, seconds}
  logic [11:0] obs;
  assign obs = {state, timeout, tick, seconds};

  always #5 clk = ~clk;

  sc_race_timebase #(
    .RaceTimebase_DIVISOR  (4),
    .RaceTimebase_DATAWIDTH(8)
  ) dut (
    .SC_RaceTimebase_CLOCK_50       (clk),
    .SC_RaceTimebase_RESET_InLow    (rst_n),
    .SC_RaceTimebase_START_InHigh   (start),
    .SC_RaceTimebase_PAUSE_InHigh   (pause),
    .SC_RaceTimebase_CLEAR_InHigh   (clear),
    .SC_RaceTimebase_LOAD_InBUS     (load),
    .SC_RaceTimebase_TICK_OutHigh   (tick),
    .SC_RaceTimebase_SECONDS_OutBUS (seconds),
    .SC_RaceTimebase_STATE_OutBUS   (state),
    .SC_RaceTimebase_TIMEOUT_OutHigh(timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL reset_async got=%h want=%h", obs, 12'h000);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL reset_release got=%h want=%h", obs, 12'h000);
    end
  endtask

  task automatic test_countdown();
    logic [11:0] exp;
    load = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (obs !== {2'b01, 1'b0, 1'b0, 8'd3}) begin
      bad++;
      $display("FAIL countdown_start got=%h want=%h", obs, {2'b01, 1'b0, 1'b0, 8'd3});
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = {(k == 12) ? 2'b11 : 2'b01, (k == 12), (k % 4 == 0), 8'(3 - k / 4)};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL countdown cycle=%0d got=%h want=%h", k, obs, exp);
      end
    end
    for (int k = 13; k <= 16; k++) begin
      step();
      total++;
      if (obs !== {2'b11, 1'b1, 1'b0, 8'd0}) begin
        bad++;
        $display("FAIL countdown_hold cycle=%0d got=%h want=%h", k, obs, {2'b11, 1'b1, 1'b0, 8'd0});
      end
    end
  endtask

  task automatic test_timeout_sticky();
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (obs !== {2'b11, 1'b1, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL timeout_start got=%h want=%h", obs, {2'b11, 1'b1, 1'b0, 8'd0});
    end
    pause = 1'b1;
    step();
    pause = 1'b0;
    total++;
    if (obs !== {2'b11, 1'b1, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL timeout_pause got=%h want=%h", obs, {2'b11, 1'b1, 1'b0, 8'd0});
    end
    do_clear();
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL timeout_clear got=%h want=%h", obs, 12'h000);
    end
  endtask

  task automatic test_pause_resume();
    load = 8'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      total++;
      if (obs !== {2'b10, 1'b0, 1'b0, 8'd5}) begin
        bad++;
        $display("FAIL paused k=%0d got=%h want=%h", k, obs, {2'b10, 1'b0, 1'b0, 8'd5});
      end
    end
    pause = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (obs !== {2'b01, 1'b0, 1'b0, 8'd5}) begin
      bad++;
      $display("FAIL resume got=%h want=%h", obs, {2'b01, 1'b0, 1'b0, 8'd5});
    end
    step();
    total++;
    if (obs !== {2'b01, 1'b0, 1'b0, 8'd5}) begin
      bad++;
      $display("FAIL resume_plus1 got=%h want=%h", obs, {2'b01, 1'b0, 1'b0, 8'd5});
    end
    step();
    total++;
    if (obs !== {2'b01, 1'b0, 1'b1, 8'd4}) begin
      bad++;
      $display("FAIL resume_tick got=%h want=%h", obs, {2'b01, 1'b0, 1'b1, 8'd4});
    end
    step();
    step();
    step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    total++;
    if (obs !== {2'b10, 1'b0, 1'b0, 8'd4}) begin
      bad++;
      $display("FAIL pause_at_terminal got=%h want=%h", obs, {2'b10, 1'b0, 1'b0, 8'd4});
    end
    do_clear();
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL paused_clear got=%h want=%h", obs, 12'h000);
    end
  endtask

  task automatic test_zero_load();
    load = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (obs !== {2'b11, 1'b1, 1'b0, 8'd0}) begin
        bad++;
        $display("FAIL zero_load k=%0d got=%h want=%h", k, obs, {2'b11, 1'b1, 1'b0, 8'd0});
      end
      step();
    end
    do_clear();
  endtask

  task automatic test_simultaneous();
    load = 8'd7;
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (obs !== {2'b01, 1'b0, 1'b0, 8'd7}) begin
        bad++;
        $display("FAIL start_held k=%0d got=%h want=%h", k, obs, {2'b01, 1'b0, 1'b0, 8'd7});
      end
    end
    step();
    total++;
    if (obs !== {2'b01, 1'b0, 1'b1, 8'd6}) begin
      bad++;
      $display("FAIL start_held_tick got=%h want=%h", obs, {2'b01, 1'b0, 1'b1, 8'd6});
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL clear_start got=%h want=%h", obs, 12'h000);
    end
    step();
    start = 1'b0;
    total++;
    if (obs !== {2'b01, 1'b0, 1'b0, 8'd7}) begin
      bad++;
      $display("FAIL restart got=%h want=%h", obs, {2'b01, 1'b0, 1'b0, 8'd7});
    end
    pause = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (obs !== {2'b10, 1'b0, 1'b0, 8'd7}) begin
      bad++;
      $display("FAIL pause_start_running got=%h want=%h", obs, {2'b10, 1'b0, 1'b0, 8'd7});
    end
    start = 1'b1;
    step();
    start = 1'b0;
    pause = 1'b0;
    total++;
    if (obs !== {2'b10, 1'b0, 1'b0, 8'd7}) begin
      bad++;
      $display("FAIL pause_start_paused got=%h want=%h", obs, {2'b10, 1'b0, 1'b0, 8'd7});
    end
    do_clear();
  endtask

  task automatic test_async_reset();
    logic [11:0] exp;
    load = 8'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL midrun_reset got=%h want=%h", obs, 12'h000);
    end
    #2 rst_n = 1'b1;
    step();
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL post_reset_idle got=%h want=%h", obs, 12'h000);
    end
    load = 8'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = {(k == 8) ? 2'b11 : 2'b01, (k == 8), (k % 4 == 0), 8'(2 - k / 4)};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL restart_count cycle=%0d got=%h want=%h", k, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_timeout_sticky();
    test_pause_resume();
    test_zero_load();
    test_simultaneous();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
